pixel_strobe_tx: RTL and testbench



---
 rtl/pixel_strobe_tx.sv | 171 +++++++++++++++++
 tb/tb_pixel_strobe_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_strobe_tx.sv
// Generic request buffer: push/pop with registered occupancy, head word always visible.
// Latency: a word pushed at one edge is poppable from the next edge on (no bypass).
// Backpressure: caller must not push when o_level == DEPTH nor pop when o_level == 0.
module pixel_strobe_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_cpu,
  input  logic                       rst_cpu_n,
  input  logic                       i_push_vld,
  input  logic [W-1:0]               i_push_dat,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk_cpu) begin
    if (!rst_cpu_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push_vld) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push_vld, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_level    = r_level;
endmodule

// Pixel-point transmitter: buffers requests and presents them to the CDC with a level strobe.
// Latency: data registered one edge after accept, strobe rises SETUP_CYCLES later; period S+T+G+1.
// Backpressure: in_ready drops while the buffer is full; a same-edge pop does not reopen it.
module pixel_strobe_tx #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                            clk_cpu,
  input  logic                            rst_cpu_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [9:0]                      in_x,
  input  logic [9:0]                      in_y,
  input  logic [2:0]                      in_brightness,
  output logic [9:0]                      cpu_pixel_x,
  output logic [9:0]                      cpu_pixel_y,
  output logic [2:0]                      cpu_pixel_brightness,
  output logic                            cpu_pixel_shift,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            busy
);
  localparam int LW     = $clog2(FIFO_DEPTH+1);
  localparam int MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_P  = (MAX_SS > GAP_CYCLES) ? MAX_SS : GAP_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
  } pix_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  pix_t          r_pix;
  logic          r_shift;

  pix_t          w_push_dat;
  pix_t          w_head_dat;
  logic [LW-1:0] w_level;
  logic          w_push;
  logic          w_pop;

  assign w_push_dat = '{x: in_x, y: in_y, b: in_brightness};
  assign in_ready   = rst_cpu_n & (w_level != LW'(FIFO_DEPTH));
  assign w_push     = in_valid & in_ready;
  // Pop decision uses the registered level, so a fresh push is never popped on its own edge.
  assign w_pop      = (r_state == S_IDLE) & (w_level != '0);

  pixel_strobe_fifo #(
    .W     ($bits(pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_cpu    (clk_cpu),
    .rst_cpu_n  (rst_cpu_n),
    .i_push_vld (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_level    (w_level)
  );

  always_ff @(posedge clk_cpu) begin
    if (!rst_cpu_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pix   <= '0;
      r_shift <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_pix   <= w_head_dat;
            r_cnt   <= CW'(SETUP_CYCLES - 1);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_shift <= 1'b1;
            r_cnt   <= CW'(STROBE_CYCLES - 1);
            r_state <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_shift <= 1'b0;
            r_cnt   <= CW'(GAP_CYCLES - 1);
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_pixel_x          = r_pix.x;
  assign cpu_pixel_y          = r_pix.y;
  assign cpu_pixel_brightness = r_pix.b;
  assign cpu_pixel_shift      = r_shift;
  assign fifo_level           = w_level;
  assign busy                 = (r_state != S_IDLE) | (w_level != '0);
endmodule

// File: tb/tb_pixel_strobe_tx.sv
// Bench for pixel_strobe_tx: timeline model of load/strobe windows plus directed literal checks.
`timescale 1ns/1ps
module tb_pixel_strobe_tx;
  localparam int DEPTH = 4;
  localparam int S = 1, T = 2, G = 1;
  localparam int NRAND = 4000;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
  } pt_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [9:0] in_x, in_y, out_x, out_y;
  logic [2:0] in_b, out_b;
  logic       shift, busy;
  logic [2:0] level;

  logic       p_valid, p_ready;
  logic [9:0] p_x, p_y, p_ox, p_oy;
  logic [2:0] p_b, p_ob;
  logic       p_shift, p_busy;
  logic [2:0] p_level;

  always #100 clk = ~clk;

  pixel_strobe_tx dut (
    .clk_cpu(clk), .rst_cpu_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_brightness(in_b),
    .cpu_pixel_x(out_x), .cpu_pixel_y(out_y), .cpu_pixel_brightness(out_b),
    .cpu_pixel_shift(shift), .fifo_level(level), .busy(busy)
  );

  pixel_strobe_tx #(.FIFO_DEPTH(4), .SETUP_CYCLES(3), .STROBE_CYCLES(5), .GAP_CYCLES(2)) dut_p (
    .clk_cpu(clk), .rst_cpu_n(rst_n), .in_valid(p_valid), .in_ready(p_ready),
    .in_x(p_x), .in_y(p_y), .in_brightness(p_b),
    .cpu_pixel_x(p_ox), .cpu_pixel_y(p_oy), .cpu_pixel_brightness(p_ob),
    .cpu_pixel_shift(p_shift), .fifo_level(p_level), .busy(p_busy)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int n_rise = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each point occupies a fixed window after its load; loads wait for the previous window.
  pt_t m_q[$];
  int  m_acc[$];
  pt_t m_data;
  int  m_tl, m_next_free;
  bit  m_has, m_live = 1'b0;

  always @(posedge clk) begin
    bit acc;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_q.delete(); m_acc.delete();
      m_data = '0; m_has = 1'b0; m_next_free = 0; m_live = 1'b1;
    end else if (m_live) begin
      acc = in_valid && (m_q.size() != DEPTH);
      if (cyc >= m_next_free && m_q.size() > 0 && m_acc[0] < cyc) begin
        m_data = m_q.pop_front();
        void'(m_acc.pop_front());
        m_tl = cyc; m_has = 1'b1;
        m_next_free = cyc + S + T + G + 1;
      end
      if (acc) begin
        m_q.push_back('{x: in_x, y: in_y, b: in_b});
        m_acc.push_back(cyc);
      end
    end
  end

  logic prev_shift = 1'b0;
  always @(negedge clk) begin
    int eshift, ebusy;
    if (m_live) begin
      eshift = (m_has && cyc >= m_tl + S && cyc < m_tl + S + T) ? 1 : 0;
      ebusy  = ((m_has && cyc < m_next_free - 1) || m_q.size() != 0) ? 1 : 0;
      chk("x", out_x, m_data.x);
      chk("y", out_y, m_data.y);
      chk("bright", out_b, m_data.b);
      chk("shift", shift, eshift);
      chk("level", level, m_q.size());
      chk("busy", busy, ebusy);
      chk("in_ready", in_ready, (rst_n && m_q.size() != DEPTH) ? 1 : 0);
      if (shift === 1'b1 && prev_shift === 1'b0) n_rise++;
      prev_shift = shift;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                       output int edge_acc);
    logic r;
    in_x = x; in_y = y; in_b = b; in_valid = 1'b1;
    edge_acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        edge_acc = cyc;
        break;
      end
    end
    if (edge_acc < 0) chk("drive_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick(); k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[6];
    int e, r0, a;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_b = '0;
    p_valid = 1'b0; p_x = '0; p_y = '0; p_b = '0;

    // Reset state
    tick(); tick();
    chk("rst_x", out_x, 0); chk("rst_shift", shift, 0); chk("rst_level", level, 0);
    chk("rst_busy", busy, 0); chk("rst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1; #1;
    chk("ready_after_release", in_ready, 1);

    // Single point accepted at edge 10
    while (cyc < 9) tick();
    in_x = 10'h155; in_y = 10'h2AA; in_b = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_edge", cyc, 10);
    tick();
    chk("single_x", out_x, 10'h155); chk("single_y", out_y, 10'h2AA);
    chk("single_b", out_b, 5); chk("single_shift11", shift, 0);
    tick(); chk("single_shift12", shift, 1);
    tick(); chk("single_shift13", shift, 1);
    tick(); chk("single_shift14", shift, 0); chk("single_busy14", busy, 1);
    tick(); tick(); chk("single_busy16", busy, 0);

    // Burst of 6 with DEPTH=4: full after 5 accepts, retry lands after the next pop
    for (int i = 0; i < 6; i++) begin
      drive(10'(i * 37 + 3), 10'(1000 - i * 11), 3'(i + 1), acc[i]);
      if (i == 4) begin
        chk("burst_full_level", level, 4);
        chk("burst_full_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    chk("burst_5th_edge", acc[4] - acc[0], 4);
    chk("burst_6th_edge", acc[5] - acc[0], 7);
    wait_idle(100);

    // Reset while strobing with 3 points queued
    for (int i = 0; i < 4; i++) drive(10'(200 + i), 10'(300 + i), 3'(7 - i), acc[i]);
    in_valid = 1'b0;
    chk("rst_q_edges", acc[3] - acc[0], 3);
    chk("rst_q_shift", shift, 1);
    chk("rst_q_level", level, 3);
    rst_n = 1'b0; #1;
    chk("rst_q_ready_low", in_ready, 0);
    tick();
    chk("rst_q_shift0", shift, 0); chk("rst_q_x0", out_x, 0);
    chk("rst_q_level0", level, 0); chk("rst_q_busy0", busy, 0);
    rst_n = 1'b1; #1;
    chk("rst_q_ready1", in_ready, 1);
    r0 = n_rise;
    repeat (20) tick();
    chk("rst_q_no_stale", n_rise - r0, 0);

    // Random traffic against the model
    r0 = n_rise;
    for (int i = 0; i < NRAND; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      drive(10'($urandom), 10'($urandom), 3'($urandom), a);
    end
    in_valid = 1'b0;
    wait_idle(200);
    chk("rand_strobes", n_rise - r0, NRAND);

    // SETUP=3 STROBE=5 GAP=2 instance
    p_x = 10'h3C1; p_y = 10'h042; p_b = 3'd6; p_valid = 1'b1;
    @(negedge clk); chk("p_ready0", p_ready, 1);
    tick();
    e = cyc;
    p_x = 10'h0F0; p_y = 10'h10F; p_b = 3'd1;
    @(negedge clk); chk("p_ready1", p_ready, 1);
    tick();
    p_valid = 1'b0;
    chk("p_load_x", p_ox, 10'h3C1);
    for (int n = 1; n <= 14; n++) begin
      chk("p_shift", p_shift, (n >= 4 && n <= 8) ? 1 : 0);
      if (n == 11) chk("p_hold_x", p_ox, 10'h3C1);
      if (n == 12) begin
        chk("p_next_x", p_ox, 10'h0F0);
        chk("p_next_y", p_oy, 10'h10F);
        chk("p_next_b", p_ob, 1);
      end
      tick();
    end
    chk("p_edge_base", cyc - e, 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
